ecc_codeword_encoder: RTL and testbench
=======================================

// Module: ecc_codeword_encoder
// PURPOSE
//  Extended-Hamming (SEC-DED) encoder: the transmit side of the ECC datapath. Takes a right-aligned
//  data word, builds (8,4), (16,11) or (32,26) codewords selected by CODEWORD_WIDTH, and emits them
//  left-aligned in a 32-bit word, the layout the error-detection/correction path checks.
//  2-stage elastic valid/ready pipeline between the register front-end and the channel.
// PARAMETERS
//  AMBA_WORD   32  codeword bus width; fixed at 32, other values unsupported
//  CNT_WIDTH   16  width of ENC_COUNT delivered-codeword counter
// PORTS
//  clk             in   1          clock, all logic on rising edge
//  rst             in   1          synchronous reset, active-high
//  CODEWORD_WIDTH  in   2          00 small(8,4), 01 medium(16,11), 10 large(32,26), 11 illegal
//  DATA_IN         in   32         data, right-aligned; bits above K-1 ignored
//  in_valid        in   1          DATA_IN/CODEWORD_WIDTH valid
//  in_ready        out  1          encoder accepts this cycle
//  CODEWORD_OUT    out  32         encoded word, left-aligned, unused low bits 0
//  out_valid       out  1          CODEWORD_OUT valid
//  out_ready       in   1          downstream accepts
//  width_err       out  1          high with out_valid when word was sent with CODEWORD_WIDTH=11
//  ENC_COUNT       out  CNT_WIDTH  number of codewords delivered (out_valid & out_ready)
// BEHAVIOUR
//  Reset: all valids 0, CODEWORD_OUT 0, width_err 0, ENC_COUNT 0; in-flight words discarded.
//  K/P: small K=4 P=3; medium K=11 P=4; large K=26 P=5. 11 encoded as large, width_err=1.
//  Column map: data bit d[i] gets column c(i) = i-th integer >=3 that is not a power of two
//   (small 3,5,6,7; medium 3,5,6,7,9..15; large 3,5,6,7,9..15,17..31).
//  Hamming parity p[j] = XOR of d[i] over all i with bit j of c(i) set.
//  Overall parity ov = XOR(d[K-1:0]) ^ XOR(p[P-1:0]) => XOR of whole CODEWORD_OUT is always 0.
//  Layout: small  [31]=ov [30:27]=d[3:0]  [26:24]=p[2:0] [23:0]=0
//          medium [31]=ov [30:20]=d[10:0] [19:16]=p[3:0] [15:0]=0
//          large  [31]=ov [30:5]=d[25:0]  [4:0]=p[4:0]
//  Pipeline: S1 registers masked data + width on in_valid&in_ready; S2 registers codeword.
//   s2_load = s1_valid & (!out_valid | out_ready); s1_load = in_valid & in_ready.
//   in_ready = !s1_valid | !out_valid | out_ready (combinational from out_ready, no other path).
//   Latency 2 cycles accept->out_valid with no backpressure; throughput 1 word/cycle.
//   CODEWORD_WIDTH sampled with each word in S1; changing it mid-stream affects only later words.
//  Handshake: CODEWORD_OUT/width_err/out_valid stable while out_valid & !out_ready.
//   Both stages full and out_ready=0 -> in_ready=0; no word dropped or duplicated.
//   Simultaneous accept and deliver in same cycle allowed in every stage.
//  ENC_COUNT +1 on each out_valid&out_ready; wraps 2^CNT_WIDTH-1 -> 0, no saturation.
//  rst mid-operation wins over all handshakes that cycle; in_ready=1 the cycle after reset.
// TESTING
//  T1 small, DATA_IN=0x0000000B, out_ready=1 -> CODEWORD_OUT=0x59000000, out_valid 2 cycles later.
//  T2 medium, DATA_IN=0x000007FF -> 0xFFFF0000; large DATA_IN=0x00000001 -> 0x80000023; 0 -> 0.
//  T3 stream 8 random large words, out_ready=0 for 4 cycles mid-stream -> in_ready drops after 2
//   accepted, output held stable, all 8 out in order, ENC_COUNT=8.
//  T4 CODEWORD_WIDTH=11, DATA_IN=0x00000001 -> 0x80000023 with width_err=1; next word width_err=0.
//  T5 rst high with both stages full -> next cycle out_valid=0, ENC_COUNT=0, in_ready=1.
//  T6 random 10k words, all widths -> XOR(CODEWORD_OUT)=0, unused bits 0, feeding output to decoder
//   with single-bit flip gives 1 error at flipped index, double flip gives 2 errors.

Source files
------------

// File: rtl/ecc_codeword_encoder.sv
// -----------------------------------------------------------------------------
// ecc_codeword_encoder
//
// Purpose:
//   Extended-Hamming (SEC-DED) encoder on the transmit side of the ECC
//   datapath. A right-aligned data word is turned into an (8,4), (16,11) or
//   (32,26) codeword, selected per word by CODEWORD_WIDTH, and is emitted
//   left-aligned in a 32-bit word. Codeword bits below the selected length
//   are driven to 0. A two-stage elastic valid/ready pipeline sits between
//   the register front-end and the channel.
//
// Ports:
//   clk            in   1          rising-edge clock
//   rst            in   1          synchronous reset, active-high
//   CODEWORD_WIDTH in   2          00 (8,4), 01 (16,11), 10 (32,26), 11 illegal
//   DATA_IN        in   AMBA_WORD  data, right-aligned; bits above K-1 ignored
//   in_valid       in   1          DATA_IN / CODEWORD_WIDTH valid
//   in_ready       out  1          encoder accepts this cycle
//   CODEWORD_OUT   out  AMBA_WORD  encoded word, left-aligned, unused low bits 0
//   out_valid      out  1          CODEWORD_OUT valid
//   out_ready      in   1          downstream accepts
//   width_err      out  1          word was sent with CODEWORD_WIDTH = 11
//   ENC_COUNT      out  CNT_WIDTH  codewords delivered, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module ecc_codeword_encoder #(
  parameter int AMBA_WORD = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           CODEWORD_WIDTH,
  input  logic [AMBA_WORD-1:0] DATA_IN,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [AMBA_WORD-1:0] CODEWORD_OUT,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 width_err,
  output logic [CNT_WIDTH-1:0] ENC_COUNT
);

  // Largest data / parity sizes; smaller codes use a prefix of the same map.
  localparam int unsigned KMAX = 32'd26;

  localparam logic [1:0] W_SMALL   = 2'b00;
  localparam logic [1:0] W_MEDIUM  = 2'b01;
  localparam logic [1:0] W_LARGE   = 2'b10;
  localparam logic [1:0] W_ILLEGAL = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Hamming helpers
  // ---------------------------------------------------------------------------

  // Column of data bit idx: the idx-th integer >= 3 that is not a power of two
  // (3,5,6,7, 9..15, 17..31). Because the map is shared by all three code
  // sizes, the smaller codes are simply the large code with upper data bits 0.
  function automatic logic [4:0] data_column(input int unsigned idx);
    logic [4:0] col;
    if (idx == 32'd0) begin
      col = 5'd3;
    end else if (idx < 32'd4) begin
      col = 5'(idx + 32'd4);
    end else if (idx < 32'd11) begin
      col = 5'(idx + 32'd5);
    end else begin
      col = 5'(idx + 32'd6);
    end
    return col;
  endfunction

  // p[j] = XOR of data bits whose column has bit j set, i.e. the XOR of the
  // columns of all set data bits.
  function automatic logic [4:0] hamming_parity(input logic [KMAX-1:0] d);
    logic [4:0] p;
    p = 5'd0;
    for (int unsigned i = 32'd0; i < KMAX; i++) begin
      p = p ^ ({5{d[i]}} & data_column(i));
    end
    return p;
  endfunction

  // Overall parity bit: makes the XOR of the whole emitted word zero.
  function automatic logic overall_parity(input logic [KMAX-1:0] d,
                                          input logic [4:0]      p);
    return (^d) ^ (^p);
  endfunction

  // Keep only the K data bits that belong to the selected code size.
  function automatic logic [KMAX-1:0] mask_data(input logic [1:0]           w,
                                                input logic [AMBA_WORD-1:0] din);
    logic [KMAX-1:0] m;
    case (w)
      W_SMALL:   m = {22'd0, din[3:0]};
      W_MEDIUM:  m = {15'd0, din[10:0]};
      W_LARGE:   m = din[KMAX-1:0];
      W_ILLEGAL: m = din[KMAX-1:0];
      default:   m = din[KMAX-1:0];
    endcase
    return m;
  endfunction

  // Assemble the left-aligned codeword. Data is pre-masked, so parity bits
  // above P-1 are already zero and the overall parity covers exactly the
  // bits that are emitted.
  function automatic logic [31:0] build_codeword(input logic [1:0]      w,
                                                 input logic [KMAX-1:0] d);
    logic [4:0]  p;
    logic        ov;
    logic [31:0] cw;
    p  = hamming_parity(d);
    ov = overall_parity(d, p);
    case (w)
      W_SMALL:   cw = {ov, d[3:0],  p[2:0], 24'd0};
      W_MEDIUM:  cw = {ov, d[10:0], p[3:0], 16'd0};
      W_LARGE:   cw = {ov, d, p};
      W_ILLEGAL: cw = {ov, d, p};
      default:   cw = {ov, d, p};
    endcase
    return cw;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                 s1_valid_q,  s1_valid_d;
  logic [KMAX-1:0]      s1_data_q,   s1_data_d;
  logic [1:0]           s1_width_q,  s1_width_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          codeword_q,  codeword_d;
  logic                 width_err_q, width_err_d;
  logic [CNT_WIDTH-1:0] enc_count_q, enc_count_d;

  logic in_ready_s;
  logic s1_load_s;
  logic s2_load_s;
  logic deliver_s;

  // Handshake decode: S1 can take a word whenever it is empty or is about to
  // move into S2; S2 moves whenever the output slot is empty or draining.
  always_comb begin
    in_ready_s = (!s1_valid_q) || (!out_valid_q) || out_ready;
    s1_load_s  = in_valid && in_ready_s;
    s2_load_s  = s1_valid_q && ((!out_valid_q) || out_ready);
    deliver_s  = out_valid_q && out_ready;
  end

  // Stage 1 next state: capture masked data and its code size with the word.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_width_d = s1_width_q;
    if (s1_load_s) begin
      s1_valid_d = 1'b1;
      s1_data_d  = mask_data(CODEWORD_WIDTH, DATA_IN);
      s1_width_d = CODEWORD_WIDTH;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: encode on transfer, hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    codeword_d  = codeword_q;
    width_err_d = width_err_q;
    if (s2_load_s) begin
      out_valid_d = 1'b1;
      codeword_d  = build_codeword(s1_width_q, s1_data_q);
      width_err_d = (s1_width_q == W_ILLEGAL);
    end else if (deliver_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Delivered-codeword counter, free-running modulo 2^CNT_WIDTH.
  always_comb begin
    if (deliver_s) begin
      enc_count_d = enc_count_q + CNT_ONE;
    end else begin
      enc_count_d = enc_count_q;
    end
  end

  // Pipeline and counter registers; reset discards any in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= {KMAX{1'b0}};
      s1_width_q  <= 2'b00;
      out_valid_q <= 1'b0;
      codeword_q  <= 32'd0;
      width_err_q <= 1'b0;
      enc_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_width_q  <= s1_width_d;
      out_valid_q <= out_valid_d;
      codeword_q  <= codeword_d;
      width_err_q <= width_err_d;
      enc_count_q <= enc_count_d;
    end
  end

  // in_ready is deliberately combinational from out_ready so a full pipeline
  // can accept a new word in the same cycle the output drains.
  assign in_ready     = in_ready_s;
  assign CODEWORD_OUT = AMBA_WORD'(codeword_q);
  assign out_valid    = out_valid_q;
  assign width_err    = width_err_q;
  assign ENC_COUNT    = enc_count_q;

endmodule

// File: tb/tb_ecc_codeword_encoder.sv
module tb_ecc_codeword_encoder;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       CODEWORD_WIDTH;
  logic [31:0]      DATA_IN;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      CODEWORD_OUT;
  logic             out_valid;
  logic             out_ready;
  logic             width_err;
  logic [CNT_W-1:0] ENC_COUNT;

  int n_vec  = 0;
  int n_miss = 0;

  logic [34:0]      exp_q[$];          // {width, width_err, codeword}
  logic [CNT_W-1:0] exp_cnt    = '0;
  logic             stall_prev = 1'b0;
  logic [32:0]      held       = '0;
  logic             t6_done    = 1'b0;

  always #5 clk = ~clk;

  ecc_codeword_encoder #(.AMBA_WORD(32), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst(rst), .CODEWORD_WIDTH(CODEWORD_WIDTH), .DATA_IN(DATA_IN),
    .in_valid(in_valid), .in_ready(in_ready), .CODEWORD_OUT(CODEWORD_OUT),
    .out_valid(out_valid), .out_ready(out_ready), .width_err(width_err),
    .ENC_COUNT(ENC_COUNT)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (positional Hamming) ----------------
  function automatic int k_of(input logic [1:0] w);
    case (w)
      2'b00:   return 4;
      2'b01:   return 11;
      default: return 26;
    endcase
  endfunction

  function automatic int p_of(input logic [1:0] w);
    case (w)
      2'b00:   return 3;
      2'b01:   return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int nth_nonpow(input int i);
    int seen = -1;
    for (int c = 1; c < 32; c++) begin
      if ((c & (c - 1)) != 0) begin
        seen++;
        if (seen == i) return c;
      end
    end
    return -1;
  endfunction

  function automatic logic [34:0] model_cw(input logic [1:0] w, input logic [31:0] din);
    int k = k_of(w);
    int p = p_of(w);
    int n = 1 << p;
    int di = 0;
    logic [31:0] pos = '0;
    logic [31:0] cw  = '0;
    for (int c = 1; c < n; c++) begin
      if ((c & (c - 1)) != 0) begin
        pos[c] = din[di];
        di++;
      end
    end
    for (int j = 0; j < p; j++) begin
      logic par = 1'b0;
      for (int c = 1; c < n; c++)
        if ((((c >> j) & 1) == 1) && (c != (1 << j))) par ^= pos[c];
      pos[1 << j] = par;
    end
    cw[31] = ^pos;
    for (int i = 0; i < k; i++) cw[31 - k + i] = din[i];
    for (int j = 0; j < p; j++) cw[31 - k - p + j] = pos[1 << j];
    return {w, (w == 2'b11), cw};
  endfunction

  // Hamming column of an emitted bit index; -1 for bits that must be 0.
  function automatic int col_of_bit(input logic [1:0] w, input int b);
    int k = k_of(w);
    int p = p_of(w);
    if (b == 31) return 0;
    if (b >= 31 - k) return nth_nonpow(b - (31 - k));
    if (b >= 31 - k - p) return 1 << (b - (31 - k - p));
    return -1;
  endfunction

  // Returns {error_count[1:0], syndrome[4:0]}; 7'h7f if an unused bit is set.
  function automatic logic [6:0] decode(input logic [1:0] w, input logic [31:0] cw);
    logic [4:0] syn = '0;
    logic [1:0] errs;
    int c;
    for (int b = 0; b < 32; b++) begin
      if (cw[b]) begin
        c = col_of_bit(w, b);
        if (c < 0) return 7'h7f;
        syn ^= 5'(c);
      end
    end
    if (((^cw) == 1'b0) && (syn == 5'd0)) errs = 2'd0;
    else if ((^cw) == 1'b1) errs = 2'd1;
    else errs = 2'd2;
    return {errs, syn};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [34:0] e;
    int n, b1, b2;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_cnt    = '0;
        stall_prev = 1'b0;
      end else begin
        check_eq("enc_count", 64'(ENC_COUNT), 64'(exp_cnt));
        if (stall_prev) begin
          check_eq("hold_valid", 64'(out_valid), 64'd1);
          check_eq("hold_word", 64'({width_err, CODEWORD_OUT}), 64'(held));
        end
        if (in_valid && in_ready) exp_q.push_back(model_cw(CODEWORD_WIDTH, DATA_IN));
        if (out_valid && out_ready) begin
          check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("codeword", 64'(CODEWORD_OUT), 64'(e[31:0]));
            check_eq("width_err", 64'(width_err), 64'(e[32]));
            check_eq("xor_zero", 64'(^CODEWORD_OUT), 64'd0);
            check_eq("dec_clean", 64'(decode(e[34:33], CODEWORD_OUT)), 64'd0);
            n  = 1 << p_of(e[34:33]);
            b1 = 31 - int'($urandom_range(0, n - 1));
            b2 = 31 - int'($urandom_range(0, n - 1));
            if (b2 == b1) b2 = (b1 == 31) ? 30 : b1 + 1;
            check_eq("dec_single",
                     64'(decode(e[34:33], CODEWORD_OUT ^ (32'd1 << b1))),
                     64'({2'd1, 5'(col_of_bit(e[34:33], b1))}));
            check_eq("dec_double",
                     64'(decode(e[34:33], CODEWORD_OUT ^ (32'd1 << b1) ^ (32'd1 << b2)) >> 5),
                     64'd2);
          end
          exp_cnt++;
        end
        stall_prev = out_valid && !out_ready;
        held       = {width_err, CODEWORD_OUT};
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [1:0] w, input logic [31:0] d);
    int guard = 0;
    CODEWORD_WIDTH = w;
    DATA_IN        = d;
    in_valid       = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_eq("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // One word through an empty pipeline with out_ready=1; checks latency too.
  task automatic send_one(input string tag, input logic [1:0] w, input logic [31:0] d,
                          input logic [31:0] exp_cw, input logic exp_err);
    CODEWORD_WIDTH = w;
    DATA_IN        = d;
    in_valid       = 1'b1;
    @(negedge clk);
    check_eq({tag, "_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_cw"}, 64'(CODEWORD_OUT), 64'(exp_cw));
    check_eq({tag, "_werr"}, 64'(width_err), 64'(exp_err));
    tick();
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0) && guard < 100) begin
      tick();
      guard++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CNT_W-1:0] base;
    rst            = 1'b1;
    in_valid       = 1'b0;
    DATA_IN        = 32'd0;
    CODEWORD_WIDTH = 2'b00;
    out_ready      = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_cw", 64'(CODEWORD_OUT), 64'd0);
    check_eq("rst_werr", 64'(width_err), 64'd0);
    check_eq("rst_count", 64'(ENC_COUNT), 64'd0);
    check_eq("rst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // T1 / T2 / masking / T4
    send_one("t1_small", 2'b00, 32'h0000_000B, 32'h5900_0000, 1'b0);
    send_one("t2_med",   2'b01, 32'h0000_07FF, 32'hFFFF_0000, 1'b0);
    send_one("t2_med1",  2'b01, 32'h0000_0001, 32'h8013_0000, 1'b0);
    send_one("t2_large", 2'b10, 32'h0000_0001, 32'h8000_0023, 1'b0);
    send_one("t2_zero",  2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0);
    send_one("mask_sm",  2'b00, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0);
    send_one("t4_w11",   2'b11, 32'h0000_0001, 32'h8000_0023, 1'b1);
    send_one("t4_next",  2'b10, 32'h0000_0001, 32'h8000_0023, 1'b0);

    // T3: backpressure mid-stream
    base = exp_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send_word(2'b10, $urandom);
      end
      begin
        tick();
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_eq("t3_ready_low", 64'(in_ready), 64'd0);
        check_eq("t3_out_valid", 64'(out_valid), 64'd1);
        check_eq("t3_accepted2", 64'(exp_q.size()), 64'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("t3_count", 64'(ENC_COUNT), 64'(base + CNT_W'(8)));

    // T5: reset with both stages full
    out_ready = 1'b0;
    send_word(2'b10, 32'h0000_1234);
    send_word(2'b01, 32'h0ABC_DEF0);
    @(negedge clk);
    check_eq("t5_full", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst            = 1'b1;
    in_valid       = 1'b1;
    DATA_IN        = 32'h0000_0055;
    CODEWORD_WIDTH = 2'b10;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_eq("t5_valid", 64'(out_valid), 64'd0);
    check_eq("t5_count", 64'(ENC_COUNT), 64'd0);
    check_eq("t5_ready", 64'(in_ready), 64'd1);
    check_eq("t5_cw", 64'(CODEWORD_OUT), 64'd0);
    tick();
    check_eq("t5_no_load", 64'(out_valid), 64'd0);
    out_ready = 1'b1;

    // T6: random widths, data and backpressure
    fork
      begin
        for (int i = 0; i < 10000; i++) send_word(2'($urandom_range(0, 3)), $urandom);
        t6_done = 1'b1;
      end
      begin
        while (!t6_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
